// File: rtl/bp_pkg.sv
// Shared helpers for the branch direction predictor: counter encoding,
// saturating counter next-state and table index hashing.
package bp_pkg;

  // Encoding of a 2-bit direction counter
  localparam int SNT = 0;  // strongly not-taken
  localparam int WNT = 1;  // weakly not-taken
  localparam int WT  = 2;  // weakly taken
  localparam int ST  = 3;  // strongly taken

  // Saturating up/down step of a cnt_w-bit counter (cnt_w <= 32)
  function automatic logic [31:0] bp_sat_next(input logic [31:0] cnt,
                                               input logic        taken,
                                               input int          cnt_w);
    logic [31:0] max_v;
    max_v = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    if (taken)
      return (cnt >= max_v) ? max_v : cnt + 32'd1;
    else
      return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  // PC index field XOR zero-extended history; PC bits above the field alias
  function automatic logic [31:0] bp_index(input logic [63:0] pc,
                                           input logic [31:0] hist,
                                           input int          pc_lsb,
                                           input int          idx_w);
    logic [63:0] sh;
    logic [31:0] mask;
    sh   = pc >> pc_lsb;
    mask = (32'd1 << idx_w) - 32'd1;
    return (sh[31:0] ^ hist) & mask;
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// One saturating direction counter with write enable, reset to INIT_CNT.
module bp_sat_cnt
  import bp_pkg::*;
#(
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt
);

  // Step the counter toward the resolved direction when this entry is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= CNT_W'(INIT_CNT);
    else if (en)
      cnt <= CNT_W'(bp_sat_next(32'(cnt), taken, CNT_W));
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch direction predictor: table of saturating counters indexed by PC,
// optionally hashed with a non-speculative global history (gshare).
// Lookup is combinational; training happens when a branch resolves.
module branch_history_table
  import bp_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int ENTRIES  = 16,
  parameter int PC_LSB   = 2,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1,
  parameter int GHR_W    = 0,
  localparam int HIST_W  = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_taken,
  input  logic              update_pred,
  output logic              mispredict,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] upd_hist;
  logic              hist_en;
  logic [IDX_W-1:0]  lkp_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [CNT_W-1:0]  cnt_q [ENTRIES];

  // With no history bits the carried history is ignored entirely
  assign hist_en  = (GHR_W > 0);
  assign upd_hist = update_hist & {HIST_W{hist_en}};

  // Lookup hashes with the live GHR; training uses the snapshot carried with the branch
  assign lkp_idx = IDX_W'(bp_index(64'(lookup_pc), 32'(ghr), PC_LSB, IDX_W));
  assign upd_idx = IDX_W'(bp_index(64'(update_pc), 32'(upd_hist), PC_LSB, IDX_W));

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    bp_sat_cnt #(
      .CNT_W    (CNT_W),
      .INIT_CNT (INIT_CNT)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (update_valid && (upd_idx == IDX_W'(i))),
      .taken (update_taken),
      .cnt   (cnt_q[i])
    );
  end

  // Read mux returns the pre-update counter; outputs forced low while in reset
  assign pred_taken = rst_n & lookup_valid & cnt_q[lkp_idx][CNT_W-1];
  assign pred_hist  = ghr;
  assign mispredict = rst_n & update_valid & (update_pred ^ update_taken);

  if (GHR_W == 0) begin : g_no_ghr
    assign ghr = '0;
  end else if (GHR_W == 1) begin : g_ghr1
    // Single-bit history remembers only the last resolved outcome
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        ghr <= '0;
      else if (update_valid)
        ghr <= update_taken;
    end
  end else begin : g_ghr
    // Shift resolved outcomes into the history, newest in the LSB
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        ghr <= '0;
      else if (update_valid)
        ghr <= {ghr[HIST_W-2:0], update_taken};
    end
  end

  // Performance counters for resolved branches and mispredictions, wrap at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (update_valid)
        perf_branches <= perf_branches + 32'd1;
      if (mispredict)
        perf_mispred <= perf_mispred + 32'd1;
    end
  end

endmodule
